// File: rtl/winocnn_pkg.sv
// Shared types for the Winograd CNN result path: tile layout, result packet and writer FSM states.
package winocnn_pkg;

   localparam int WINO_DATA_W = 16;
   localparam int WINO_IDX_W  = 9;
   localparam int WINO_OD_W   = 8;

   typedef logic signed [WINO_DATA_W-1:0] elem_t;
   typedef elem_t [5:0][5:0]              tile6_t;

   typedef enum logic {
      SIZE_6X6 = 1'b0,
      SIZE_4X4 = 1'b1
   } size_type_e;

   typedef struct packed {
      tile6_t                 tile;
      size_type_e             size_type;
      logic [WINO_OD_W-1:0]   od;
      logic [WINO_IDX_W-1:0]  x;
      logic [WINO_IDX_W-1:0]  y;
      logic                   first;
   } result_pkt_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_ELEM = 3'd2,
      ST_RD   = 3'd3,
      ST_WB   = 3'd4
   } wr_state_e;

endpackage

// File: rtl/result_tile_fifo.sv
// Small synchronous FIFO of result packets buffering tiles ahead of the serializing writer.
module result_tile_fifo
   import winocnn_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_push,
   input  result_pkt_t i_data,
   input  logic        i_pop,
   output result_pkt_t o_data,
   output logic        o_full,
   output logic        o_empty
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   result_pkt_t      r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [PTR_W:0]   r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + PTR_W'(1);
         if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
         if (i_push && !i_pop)
            r_count <= r_count + (PTR_W+1)'(1);
         else if (i_pop && !i_push)
            r_count <= r_count - (PTR_W+1)'(1);
      end
   end

   // storage carries data only, so it is left out of reset
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wptr] <= i_data;
   end

   assign o_data  = r_mem[r_rptr];
   assign o_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/pe_result_writer.sv
// Serializes Winograd result tiles into single-element OFM SRAM writes (overwrite or read-modify-write
// accumulate), clipping to the HxW map. Define WRITER_SAT_EN for a saturating accumulate.
module pe_result_writer
   import winocnn_pkg::*;
#(
   parameter int DATA_W     = WINO_DATA_W,
   parameter int IDX_W      = WINO_IDX_W,
   parameter int OD_W       = WINO_OD_W,
   parameter int ADDR_W     = 24,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  tile6_t            tile_i,
   input  logic              tile_valid_i,
   output logic              tile_ready_o,
   input  logic              tile_size_type_i,
   input  logic [OD_W-1:0]   tile_od_i,
   input  logic [IDX_W-1:0]  tile_x_i,
   input  logic [IDX_W-1:0]  tile_y_i,
   input  logic              tile_first_i,
   input  logic [IDX_W:0]    cfg_h_i,
   input  logic [IDX_W:0]    cfg_w_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_we_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              mem_re_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o,
   output logic [15:0]       tiles_done_o
);

   wr_state_e                r_state;
   wr_state_e                w_state_nxt;
   result_pkt_t              r_pkt;
   logic [2:0]               r_i;
   logic [2:0]               r_j;
   logic signed [DATA_W-1:0] r_rdata;
   logic [15:0]              r_tiles_done;

   result_pkt_t              w_push_pkt;
   result_pkt_t              w_head;
   logic                     w_push;
   logic                     w_pop;
   logic                     w_full;
   logic                     w_empty;
   logic                     w_advance;
   logic                     w_last;
   logic [2:0]               w_last_idx;
   logic [IDX_W:0]           w_row;
   logic [IDX_W:0]           w_col;
   logic                     w_clip;
   logic [ADDR_W-1:0]        w_addr;
   logic signed [DATA_W-1:0] w_elem;

   function automatic logic signed [DATA_W-1:0] acc_sum(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
`ifdef WRITER_SAT_EN
      logic signed [DATA_W:0] s;
      s = (DATA_W+1)'(a) + (DATA_W+1)'(b);
      // the two top bits disagree only when the sum left the DATA_W range
      if (s[DATA_W] != s[DATA_W-1])
         return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      return s[DATA_W-1:0];
`else
      return a + b;
`endif
   endfunction

   always_comb begin
      w_push_pkt           = '0;
      w_push_pkt.tile      = tile_i;
      w_push_pkt.size_type = size_type_e'(tile_size_type_i);
      w_push_pkt.od        = tile_od_i;
      w_push_pkt.x         = tile_x_i;
      w_push_pkt.y         = tile_y_i;
      w_push_pkt.first     = tile_first_i;
   end

   assign w_push = tile_valid_i && !w_full;

   result_tile_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (w_push_pkt),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_last_idx = (r_pkt.size_type == SIZE_4X4) ? 3'd3 : 3'd5;
   assign w_last     = (r_i == w_last_idx) && (r_j == w_last_idx);
   assign w_row      = (IDX_W+1)'(r_pkt.x) + (IDX_W+1)'(r_i);
   assign w_col      = (IDX_W+1)'(r_pkt.y) + (IDX_W+1)'(r_j);
   assign w_clip     = (w_row >= cfg_h_i) || (w_col >= cfg_w_i);
   assign w_elem     = r_pkt.tile[r_i][r_j];
   assign w_addr     = ADDR_W'(r_pkt.od) * ADDR_W'(cfg_h_i) * ADDR_W'(cfg_w_i)
                     + ADDR_W'(w_row) * ADDR_W'(cfg_w_i) + ADDR_W'(w_col);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_advance   = 1'b0;
      mem_we_o    = 1'b0;
      mem_re_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) w_state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            w_pop       = 1'b1;
            w_state_nxt = ST_ELEM;
         end
         ST_ELEM: begin
            if (w_clip) begin
               w_advance = 1'b1;
            end else if (r_pkt.first) begin
               mem_we_o    = 1'b1;
               mem_addr_o  = w_addr;
               mem_wdata_o = w_elem;
               w_advance   = 1'b1;
            end else begin
               mem_re_o    = 1'b1;
               mem_addr_o  = w_addr;
               w_state_nxt = ST_RD;
            end
         end
         ST_RD: begin
            w_state_nxt = ST_WB;
         end
         ST_WB: begin
            mem_we_o    = 1'b1;
            mem_addr_o  = w_addr;
            mem_wdata_o = acc_sum(r_rdata, w_elem);
            w_advance   = 1'b1;
            w_state_nxt = ST_ELEM;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_advance && w_last)
         w_state_nxt = w_empty ? ST_IDLE : ST_LOAD;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_i          <= '0;
         r_j          <= '0;
         r_tiles_done <= '0;
      end else if (w_pop) begin
         r_i <= '0;
         r_j <= '0;
      end else if (w_advance) begin
         if (r_j == w_last_idx) begin
            r_j <= '0;
            r_i <= r_i + 3'd1;
         end else begin
            r_j <= r_j + 3'd1;
         end
         if (w_last) r_tiles_done <= r_tiles_done + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_pop)              r_pkt   <= w_head;
      if (r_state == ST_RD)   r_rdata <= mem_rdata_i;
   end

   assign tile_ready_o = !w_full;
   assign busy_o       = !w_empty || (r_state != ST_IDLE);
   assign tiles_done_o = r_tiles_done;

endmodule

// File: tb/tb_pe_result_writer.sv
// Bench for pe_result_writer: directed scenarios plus randomized tiles against a tile-level reference model.
module tb_pe_result_writer;
   import winocnn_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   tile6_t      tile_drv = '0;
   logic        tile_valid = 1'b0;
   logic        tile_ready;
   logic        tile_size = 1'b0;
   logic [7:0]  tile_od = '0;
   logic [8:0]  tile_x = '0;
   logic [8:0]  tile_y = '0;
   logic        tile_first = 1'b0;
   logic [9:0]  cfg_h = 10'd16;
   logic [9:0]  cfg_w = 10'd16;
   logic [23:0] mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic        mem_re;
   logic [15:0] mem_rdata = '0;
   logic        busy;
   logic [15:0] tiles_done;

   pe_result_writer dut (
      .clk              (clk),
      .reset            (reset),
      .tile_i           (tile_drv),
      .tile_valid_i     (tile_valid),
      .tile_ready_o     (tile_ready),
      .tile_size_type_i (tile_size),
      .tile_od_i        (tile_od),
      .tile_x_i         (tile_x),
      .tile_y_i         (tile_y),
      .tile_first_i     (tile_first),
      .cfg_h_i          (cfg_h),
      .cfg_w_i          (cfg_w),
      .mem_addr_o       (mem_addr),
      .mem_we_o         (mem_we),
      .mem_wdata_o      (mem_wdata),
      .mem_re_o         (mem_re),
      .mem_rdata_i      (mem_rdata),
      .busy_o           (busy),
      .tiles_done_o     (tiles_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      int          addr;
      logic [15:0] data;
   } ev_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] sram    [4096];
   logic [15:0] ref_mem [4096];
   ev_t         exp_q [$];
   int          exp_done = 0;
   int          n_ev = 0;
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          first_wr_addr = -1;
   logic [15:0] first_wr_data = '0;
   int          last_wr_addr = -1;
   logic [15:0] last_wr_data = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // behavioural SRAM: read data is presented one cycle after the read strobe
   always @(posedge clk) begin
      if (mem_we) sram[mem_addr[11:0]] <= mem_wdata;
      if (mem_re) mem_rdata <= sram[mem_addr[11:0]];
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("strobe_exclusive", 32'(mem_we && mem_re), 0);
         if (!mem_we && !mem_re) begin
            chk("idle_addr", 32'(mem_addr), 0);
            chk("idle_wdata", 32'(mem_wdata), 0);
         end else begin
            chk("access_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               ev_t e;
               e = exp_q.pop_front();
               chk("access_kind", 32'(mem_we), 32'(e.wr));
               chk("access_addr", 32'(mem_addr), 32'(e.addr));
               if (e.wr) chk("access_wdata", 32'(mem_wdata), 32'(e.data));
            end
            n_ev++;
            if (mem_we) begin
               if (wr_cnt == 0) begin
                  first_wr_addr = int'(mem_addr);
                  first_wr_data = mem_wdata;
               end
               last_wr_addr = int'(mem_addr);
               last_wr_data = mem_wdata;
               wr_cnt++;
            end
            if (mem_re) rd_cnt++;
         end
      end
   end

   function automatic logic [15:0] ref_acc(input logic [15:0] m, input logic [15:0] t);
      int s;
      s = int'($signed(m)) + int'($signed(t));
`ifdef WRITER_SAT_EN
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
`endif
      return 16'(s);
   endfunction

   // tile-level reference: expected SRAM access sequence and element-cycle cost of one tile
   task automatic model_tile(input tile6_t t, input bit sz4, input int od, input int x, input int y,
                             input bit first, output int cyc);
      int n, row, col, addr;
      ev_t e;
      n   = sz4 ? 4 : 6;
      cyc = 0;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < n; j++) begin
            row = x + i;
            col = y + j;
            if (row >= int'(cfg_h) || col >= int'(cfg_w)) begin
               cyc += 1;
            end else begin
               addr = (od * int'(cfg_h) * int'(cfg_w) + row * int'(cfg_w) + col) % (1 << 24);
               if (first) begin
                  e = '{wr: 1'b1, addr: addr, data: t[i][j]};
                  exp_q.push_back(e);
                  ref_mem[addr] = t[i][j];
                  cyc += 1;
               end else begin
                  e = '{wr: 1'b0, addr: addr, data: 16'h0};
                  exp_q.push_back(e);
                  e = '{wr: 1'b1, addr: addr, data: ref_acc(ref_mem[addr], t[i][j])};
                  exp_q.push_back(e);
                  ref_mem[addr] = e.data;
                  cyc += 3;
               end
            end
         end
      end
      exp_done++;
   endtask

   task automatic push_tile(input tile6_t t, input bit sz4, input int od, input int x, input int y,
                            input bit first, output int cyc);
      int waited;
      waited = 0;
      @(negedge clk);
      while (!tile_ready && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      chk("push_ready_wait", 32'(waited < 2000), 1);
      tile_drv   = t;
      tile_size  = sz4;
      tile_od    = 8'(od);
      tile_x     = 9'(x);
      tile_y     = 9'(y);
      tile_first = first;
      tile_valid = 1'b1;
      model_tile(t, sz4, od, x, y, first, cyc);
      @(posedge clk);
      #1;
      tile_valid = 1'b0;
   endtask

   task automatic wait_idle(output int busy_cyc);
      busy_cyc = 0;
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         if (!busy) break;
         busy_cyc++;
      end
      chk("idle_reached", 32'(busy), 0);
   endtask

   task automatic clear_obs();
      wr_cnt = 0;
      rd_cnt = 0;
      first_wr_addr = -1;
      last_wr_addr = -1;
   endtask

   task automatic init_mem();
      logic [15:0] v;
      for (int k = 0; k < 4096; k++) begin
         v = 16'($urandom);
         sram[k]    = v;
         ref_mem[k] = v;
      end
   endtask

   function automatic tile6_t rand_tile();
      tile6_t t;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++)
            t[i][j] = 16'($urandom);
      return t;
   endfunction

   task automatic run_single(input string tag, input tile6_t t, input bit sz4, input int od,
                             input int x, input int y, input bit first);
      int cyc, bc;
      push_tile(t, sz4, od, x, y, first, cyc);
      wait_idle(bc);
      // one IDLE cycle with a non-empty buffer, one LOAD, then the element cycles
      chk({tag, "_busy_cycles"}, 32'(bc), 32'(2 + cyc));
      chk({tag, "_tiles_done"}, 32'(tiles_done), 32'(exp_done));
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ready"}, 32'(tile_ready), 1);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_we"}, 32'(mem_we), 0);
      chk({tag, "_re"}, 32'(mem_re), 0);
      chk({tag, "_addr"}, 32'(mem_addr), 0);
      chk({tag, "_wdata"}, 32'(mem_wdata), 0);
      chk({tag, "_done"}, 32'(tiles_done), 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tile6_t t;
      int     cyc, bc, ev0, waited;

      init_mem();
      #1;
      chk_idle_outputs("reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk_idle_outputs("post_reset");

      // overwrite 6x6, od 1, tile[i][j] = 10i+j
      cfg_h = 10'd16;
      cfg_w = 10'd16;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++)
            t[i][j] = 16'(10 * i + j);
      clear_obs();
      run_single("ovw6", t, 1'b0, 1, 0, 0, 1'b1);
      chk("ovw6_wr_cnt", 32'(wr_cnt), 36);
      chk("ovw6_first_addr", 32'(first_wr_addr), 256);
      chk("ovw6_last_addr", 32'(last_wr_addr), 341);
      chk("ovw6_last_data", 32'(last_wr_data), 55);

      // 4x4 mostly clipped at the map corner
      clear_obs();
      run_single("clip4", rand_tile(), 1'b1, 0, 14, 14, 1'b1);
      chk("clip4_wr_cnt", 32'(wr_cnt), 4);
      chk("clip4_first_addr", 32'(first_wr_addr), 238);
      chk("clip4_last_addr", 32'(last_wr_addr), 255);

      // accumulate onto a preloaded value
      sram[0]    = 16'd100;
      ref_mem[0] = 16'd100;
      t = rand_tile();
      t[0][0] = 16'sd5;
      clear_obs();
      run_single("acc", t, 1'b1, 0, 0, 0, 1'b0);
      chk("acc_first_addr", 32'(first_wr_addr), 0);
      chk("acc_first_data", 32'(first_wr_data), 105);
      chk("acc_rd_cnt", 32'(rd_cnt), 16);

      // accumulate overflow: only element (0,0) lies inside a 1x1 map
      cfg_h = 10'd1;
      cfg_w = 10'd1;
      sram[0]    = 16'd32760;
      ref_mem[0] = 16'd32760;
      t = rand_tile();
      t[0][0] = 16'sd20;
      clear_obs();
      run_single("sat", t, 1'b1, 0, 0, 0, 1'b0);
      chk("sat_wr_cnt", 32'(wr_cnt), 1);
`ifdef WRITER_SAT_EN
      chk("sat_data", 32'(last_wr_data), 32'h7FFF);
`else
      chk("sat_data", 32'(last_wr_data), 32'h800C);
`endif

      // back-to-back: two buffered tiles fill the FIFO before the first is popped
      cfg_h = 10'd16;
      cfg_w = 10'd16;
      ev0 = exp_done;
      push_tile(rand_tile(), 1'b0, 2, 3, 5, 1'b0, cyc);
      push_tile(rand_tile(), 1'b0, 1, 10, 12, 1'b1, cyc);
      chk("b2b_ready_full", 32'(tile_ready), 0);
      push_tile(rand_tile(), 1'b0, 2, 3, 5, 1'b0, cyc);
      wait_idle(bc);
      chk("b2b_tiles_done", 32'(tiles_done), 32'(ev0 + 3));
      chk("b2b_queue_drained", 32'(exp_q.size()), 0);

      // randomized batches, cfg held stable per batch
      for (int b = 0; b < 5; b++) begin
         cfg_h = 10'($urandom_range(4, 20));
         cfg_w = 10'($urandom_range(4, 20));
         for (int k = 0; k < 4; k++)
            push_tile(rand_tile(), 1'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, int'(cfg_h) + 1), $urandom_range(0, int'(cfg_w) + 1),
                      1'($urandom), cyc);
         wait_idle(bc);
         chk("rand_tiles_done", 32'(tiles_done), 32'(exp_done));
         chk("rand_queue_drained", 32'(exp_q.size()), 0);
      end

      // memory image after all traffic
      bc = 0;
      for (int k = 0; k < 4096; k++)
         if (sram[k] !== ref_mem[k]) bc++;
      chk("mem_image_mismatches", 32'(bc), 0);

      // reset while element 10 of a tile is being written
      cfg_h = 10'd16;
      cfg_w = 10'd16;
      ev0 = n_ev;
      push_tile(rand_tile(), 1'b0, 0, 0, 0, 1'b1, cyc);
      waited = 0;
      while (n_ev < ev0 + 11 && waited < 200) begin
         @(negedge clk);
         #2;
         waited++;
      end
      chk("rst_mid_reached", 32'(n_ev), 32'(ev0 + 11));
      reset = 1'b1;
      #1;
      chk_idle_outputs("rst_mid");
      exp_q.delete();
      exp_done = 0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      init_mem();
      clear_obs();
      run_single("after_rst", rand_tile(), 1'b0, 0, 2, 2, 1'b1);
      chk("after_rst_wr_cnt", 32'(wr_cnt), 36);
      chk("after_rst_tiles_done", 32'(tiles_done), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
